cursor_ctrl: RTL and testbench

Cursor controller for the 8x8 LED-matrix drawing lab. It turns the left/right keys into single-step or auto-repeat column moves with wrap-around, and takes the row from the row-select switches. Paint presses become one-cycle write strobes toward the pixel frame buffer. It owns the registered cursor position that the display and frame-buffer logic consume.

---
 rtl/cursor_ctrl.sv | 150 +++++++++++++++
 tb/tb_cursor_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_ctrl.sv
// Purpose: 8x8 LED-matrix cursor; keys step the column with tap/auto-repeat, switches pick the row, paint presses become write strobes.
// Latency: one edge from a sampled key, row switch or paint press to the registered cursor, move_pulse and write strobe.
// Backpressure: none; the frame-buffer write strobe is fire-and-forget and the cursor is always ready.
module cursor_ctrl #(
    parameter int HOLD_CYCLES   = 1_500_000,
    parameter int REPEAT_CYCLES = 375_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_left,
    input  logic       key_right,
    input  logic [7:0] row_select,
    input  logic       paint,
    output logic [2:0] cur_x,
    output logic [2:0] cur_y,
    output logic       move_pulse,
    output logic       wr_en,
    output logic [5:0] wr_addr
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir_left;
    logic             dir_left_nxt;
    logic             step;
    logic             step_left;
    logic             abort;
    logic             one_key;
    logic             paint_prev;
    logic             press;
    logic [2:0]       y_nxt;

    // Exactly one key down starts a move; the latched key released or the other key pressed cancels it.
    assign one_key = key_left ^ key_right;
    assign abort   = dir_left ? (!key_left || key_right) : (!key_right || key_left);
    assign press   = paint && !paint_prev;

    // FSM state, repeat counter and latched direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dir_left <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dir_left <= dir_left_nxt;
        end
    end

    // Next-state selection for the tap / hold / repeat sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (one_key) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (abort)                  state_nxt = S_IDLE;
                else if (cnt == HOLD_LAST)  state_nxt = S_REPEAT;
            end
            S_REPEAT: begin
                if (abort) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Step request, step direction and counter update for the current state.
    always_comb begin
        step         = 1'b0;
        step_left    = dir_left;
        dir_left_nxt = dir_left;
        cnt_nxt      = cnt;
        case (state)
            S_IDLE: begin
                if (one_key) begin
                    step         = 1'b1;
                    step_left    = key_left;
                    dir_left_nxt = key_left;
                    cnt_nxt      = '0;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    cnt_nxt = '0;
                end else if (cnt == HOLD_LAST) begin
                    step    = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_REPEAT: begin
                if (abort) begin
                    cnt_nxt = '0;
                end else if (cnt == REPEAT_LAST) begin
                    step    = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    // Row follows the highest set switch; all switches off keeps the current row.
    always_comb begin
        y_nxt = cur_y;
        for (int i = 0; i < 8; i++) begin
            if (row_select[i]) y_nxt = 3'(i);
        end
    end

    // Cursor, move pulse and paint strobe; the write address captures the position before this edge's step.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x      <= 3'd0;
            cur_y      <= 3'd0;
            move_pulse <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 6'd0;
            paint_prev <= 1'b0;
        end else begin
            if (step) cur_x <= step_left ? (cur_x + 3'd1) : (cur_x - 3'd1);
            cur_y      <= y_nxt;
            move_pulse <= step;
            paint_prev <= paint;
            wr_en      <= press;
            if (press) wr_addr <= {cur_y, cur_x};
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
module tb_cursor_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic [7:0] row_select = 8'd0;
    logic       paint = 1'b0;
    logic [2:0] cur_x;
    logic [2:0] cur_y;
    logic       move_pulse;
    logic       wr_en;
    logic [5:0] wr_addr;

    int tests = 0;
    int fails = 0;

    cursor_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_left   (key_left),
        .key_right  (key_right),
        .row_select (row_select),
        .paint      (paint),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .move_pulse (move_pulse),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr)
    );

    always #5 clk = ~clk;

    // Reference model: tracks how many edges the active key has been held since its first step.
    logic [2:0] m_x, m_y;
    logic       m_mp, m_wr, m_pprev;
    logic [5:0] m_addr;
    int         m_act;   // 0 none, 1 left, 2 right
    int         m_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic kl, input logic kr,
                              input logic [7:0] row, input logic p);
        logic step, sl, held, press;
        if (r) begin
            m_x = 0; m_y = 0; m_mp = 0; m_wr = 0; m_addr = 0;
            m_act = 0; m_run = 0; m_pprev = 0;
        end else begin
            step = 0; sl = 0;
            if (m_act == 0) begin
                if (kl != kr) begin
                    step = 1; sl = kl; m_act = kl ? 1 : 2; m_run = 0;
                end
            end else begin
                held = (m_act == 1) ? (kl && !kr) : (kr && !kl);
                if (!held) begin
                    m_act = 0;
                end else begin
                    m_run++;
                    if (m_run == HOLD || (m_run > HOLD && (m_run - HOLD) % REP == 0)) begin
                        step = 1; sl = (m_act == 1);
                    end
                end
            end
            press = p && !m_pprev;
            m_wr = press;
            if (press) m_addr = {m_y, m_x};
            m_pprev = p;
            m_mp = step;
            if (step) m_x = sl ? m_x + 3'd1 : m_x - 3'd1;
            for (int i = 0; i < 8; i++) if ((row >> i) != 0) m_y = 3'(i);
        end
    endtask

    task automatic tick(input logic r, input logic kl, input logic kr,
                        input logic [7:0] row, input logic p);
        reset = r; key_left = kl; key_right = kr; row_select = row; paint = p;
        @(posedge clk);
        model_edge(r, kl, kr, row, p);
        #1;
        check("model cur_x", cur_x, m_x);
        check("model cur_y", cur_y, m_y);
        check("model move_pulse", move_pulse, m_mp);
        check("model wr_en", wr_en, m_wr);
        check("model wr_addr", wr_addr, m_addr);
    endtask

    typedef struct {
        logic       r, kl, kr;
        logic [7:0] row;
        logic       p;
        logic [2:0] ex, ey;
        logic       emp, ewr;
        logic [5:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, kl, kr, input logic [7:0] row, input logic p,
                       input logic [2:0] ex, ey, input logic emp, ewr, input logic [5:0] eaddr);
        vec_t v;
        v.r = r; v.kl = kl; v.kr = kr; v.row = row; v.p = p;
        v.ex = ex; v.ey = ey; v.emp = emp; v.ewr = ewr; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        logic [2:0] x0;
        logic exp_mp;

        //   r  kl kr row    p   x  y  mp wr addr
        add(1, 1, 1, 8'h00, 0,  0, 0, 0, 0, 6'd0);   // reset with keys held
        add(1, 1, 1, 8'hFF, 1,  0, 0, 0, 0, 6'd0);
        add(0, 1, 0, 8'h00, 0,  1, 0, 1, 0, 6'd0);   // left still held -> new press
        add(0, 0, 0, 8'h00, 0,  1, 0, 0, 0, 6'd0);
        add(0, 0, 1, 8'h00, 0,  0, 0, 1, 0, 6'd0);
        add(0, 0, 0, 8'h00, 0,  0, 0, 0, 0, 6'd0);
        add(0, 0, 1, 8'h00, 0,  7, 0, 1, 0, 6'd0);   // 0 - 1 wraps to 7
        add(0, 0, 0, 8'h00, 0,  7, 0, 0, 0, 6'd0);
        add(0, 1, 0, 8'h00, 0,  0, 0, 1, 0, 6'd0);   // 7 + 1 wraps to 0
        add(0, 0, 0, 8'h00, 0,  0, 0, 0, 0, 6'd0);
        add(0, 0, 0, 8'h24, 0,  0, 5, 0, 0, 6'd0);   // highest set bit 5
        add(0, 0, 0, 8'h00, 0,  0, 5, 0, 0, 6'd0);   // no switch -> hold
        add(0, 0, 0, 8'h80, 0,  0, 7, 0, 0, 6'd0);
        add(0, 0, 0, 8'h01, 0,  0, 0, 0, 0, 6'd0);
        add(0, 1, 0, 8'h24, 0,  1, 5, 1, 0, 6'd0);
        add(0, 0, 0, 8'h00, 0,  1, 5, 0, 0, 6'd0);
        add(0, 1, 0, 8'h00, 0,  2, 5, 1, 0, 6'd0);
        add(0, 0, 0, 8'h00, 0,  2, 5, 0, 0, 6'd0);
        add(0, 1, 0, 8'h00, 0,  3, 5, 1, 0, 6'd0);
        add(0, 0, 0, 8'h00, 0,  3, 5, 0, 0, 6'd0);
        add(0, 0, 0, 8'h00, 1,  3, 5, 0, 1, 6'b101_011); // paint press
        add(0, 0, 0, 8'h00, 1,  3, 5, 0, 0, 6'b101_011); // held: no repeat write
        add(0, 0, 0, 8'h00, 1,  3, 5, 0, 0, 6'b101_011);
        add(0, 0, 0, 8'h00, 1,  3, 5, 0, 0, 6'b101_011);
        add(0, 0, 0, 8'h00, 0,  3, 5, 0, 0, 6'b101_011);
        add(0, 1, 0, 8'h00, 1,  4, 5, 1, 1, 6'b101_011); // paint + step: pre-step x
        add(0, 0, 0, 8'h00, 0,  4, 5, 0, 0, 6'b101_011);
        add(0, 1, 0, 8'h80, 0,  5, 7, 1, 0, 6'b101_011); // row change + step together
        add(0, 0, 0, 8'h00, 0,  5, 7, 0, 0, 6'b101_011);

        m_x = 0; m_y = 0; m_mp = 0; m_wr = 0; m_addr = 0; m_act = 0; m_run = 0; m_pprev = 0;

        foreach (vecs[i]) begin
            tick(vecs[i].r, vecs[i].kl, vecs[i].kr, vecs[i].row, vecs[i].p);
            check($sformatf("vec%0d cur_x", i), cur_x, vecs[i].ex);
            check($sformatf("vec%0d cur_y", i), cur_y, vecs[i].ey);
            check($sformatf("vec%0d move_pulse", i), move_pulse, vecs[i].emp);
            check($sformatf("vec%0d wr_en", i), wr_en, vecs[i].ewr);
            check($sformatf("vec%0d wr_addr", i), wr_addr, vecs[i].eaddr);
        end

        // Auto-repeat: steps at held edges 0, 8, 11, 14, 17.
        tick(1, 0, 0, 8'h00, 0);
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            tick(0, 1, 0, 8'h00, 0);
            exp_mp = (e == 0 || e == 8 || e == 11 || e == 14 || e == 17);
            check($sformatf("repeat pulse e%0d", e), move_pulse, exp_mp);
            if (move_pulse) pulses++;
        end
        check("repeat pulse count", pulses, 5);
        check("repeat final x", cur_x, 3'd5);
        tick(0, 0, 0, 8'h00, 0);

        // Abort: both keys held stops all stepping, releasing left lets right step once.
        tick(1, 0, 0, 8'h00, 0);
        for (int e = 0; e < 5; e++) tick(0, 1, 0, 8'h00, 0);
        check("abort x after left", cur_x, 3'd1);
        pulses = 0;
        for (int e = 0; e < 12; e++) begin
            tick(0, 1, 1, 8'h00, 0);
            if (move_pulse) pulses++;
        end
        check("abort both pulses", pulses, 0);
        check("abort both x", cur_x, 3'd1);
        tick(0, 0, 1, 8'h00, 0);
        check("abort right step x", cur_x, 3'd0);
        check("abort right pulse", move_pulse, 1'b1);
        tick(0, 0, 0, 8'h00, 0);

        // Left released and right pressed on the next edge: pass through IDLE first.
        tick(0, 1, 0, 8'h00, 0);
        tick(0, 1, 0, 8'h00, 0);
        x0 = cur_x;
        tick(0, 0, 1, 8'h00, 0);
        check("l2r no step", move_pulse, 1'b0);
        tick(0, 0, 1, 8'h00, 0);
        check("l2r step pulse", move_pulse, 1'b1);
        check("l2r step x", cur_x, x0 - 3'd1);
        tick(0, 0, 0, 8'h00, 0);

        // Reset mid-REPEAT with left held, then release reset with left still held.
        for (int e = 0; e < 12; e++) tick(0, 1, 0, 8'h00, 0);
        tick(1, 1, 0, 8'h00, 0);
        check("rst mid repeat x", cur_x, 3'd0);
        tick(0, 1, 0, 8'h00, 0);
        check("rst release x", cur_x, 3'd1);
        check("rst release pulse", move_pulse, 1'b1);

        // Paint held through reset writes once on the first post-reset edge.
        tick(1, 0, 0, 8'h00, 1);
        tick(0, 0, 0, 8'h00, 1);
        check("paint thru rst wr", wr_en, 1'b1);
        tick(0, 0, 0, 8'h00, 1);
        check("paint thru rst once", wr_en, 1'b0);

        // Randomised sessions with key patterns held for random lengths.
        for (int s = 0; s < 250; s++) begin
            int len;
            logic kl, kr;
            logic [7:0] row;
            logic p;
            len = $urandom_range(1, 16);
            kl = $urandom_range(0, 2) != 0;
            kr = $urandom_range(0, 3) == 0;
            row = 8'h00;
            p = 1'b0;
            for (int e = 0; e < len; e++) begin
                if ($urandom_range(0, 3) == 0) row = 8'($urandom);
                else row = 8'h00;
                if ($urandom_range(0, 2) == 0) p = ~p;
                tick(($urandom_range(0, 99) == 0), kl, kr, row, p);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
